regfile_arbiter: RTL

- Sits between the CPU core and the 32x32 register file (2 synchronous read ports, 1 write port; read data valid one cycle after address).
- After reset, sequences a clear of every register, with the stack pointer preloaded.
- Afterwards, shares the register-file ports between the CPU datapath and a debug/loader requester. The CPU has priority; a bounded-wait rule prevents debug starvation.

---
 rtl/regfile_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/regfile_arbiter.sv
// regfile_arbiter: shares a 2R/1W register file between the CPU and a debug/loader port.
// Optional REGFILE_INIT_SWEEP_EN: after reset, clear every register and preload the SP.
module regfile_arbiter #(
    parameter int              NREG     = 32,
    parameter int              AW       = 5,
    parameter int              DW       = 32,
    parameter int              SP_IDX   = 29,
    parameter logic [DW-1:0]   SP_INIT  = 32'h0000_3FFC,
    parameter int              MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_waddr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic [AW-1:0] cpu_raddr1,
    input  logic [AW-1:0] cpu_raddr2,
    output logic          cpu_stall,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_gnt,
    output logic          dbg_rvalid,
    output logic [DW-1:0] dbg_rdata,
    input  logic [DW-1:0] rf_rdata1,
    output logic          rf_we,
    output logic [AW-1:0] rf_w1,
    output logic [DW-1:0] rf_wdata,
    output logic [AW-1:0] rf_r1,
    output logic [AW-1:0] rf_r2,
    output logic          init_done
);

    // state    | meaning
    // S_INIT   | sweeping registers 0..NREG-1, CPU stalled
    // S_RUN    | CPU owns the ports, debug may be granted
    // S_DBG_RD | debug read data returning on rf_rdata1
    typedef enum logic [1:0] {S_INIT, S_RUN, S_DBG_RD} state_t;

    localparam int WCW = $clog2(MAX_WAIT + 1);

`ifdef REGFILE_INIT_SWEEP_EN
    localparam state_t RST_STATE = S_INIT;
    localparam logic   RST_DONE  = 1'b0;
`else
    localparam state_t RST_STATE = S_RUN;
    localparam logic   RST_DONE  = 1'b1;
`endif

    state_t         r_state;
    logic [WCW-1:0] r_wait_cnt;
    logic           r_gnt;
    logic           r_rvalid;
    logic [DW-1:0]  r_rdata;
    logic           r_init_done;
`ifdef REGFILE_INIT_SWEEP_EN
    logic [AW-1:0]  r_idx;
`endif

    logic w_dbg_elig;
    logic w_grant;

    // A request seen during the dbg_gnt cycle is the one just served.
    assign w_dbg_elig = (r_state == S_RUN) && dbg_req && !r_gnt;
    assign w_grant    = w_dbg_elig && (!cpu_we || (r_wait_cnt == WCW'(MAX_WAIT)));

    always_comb begin
        rf_r1     = cpu_raddr1;
        rf_r2     = cpu_raddr2;
        rf_we     = cpu_we && (cpu_waddr != '0);
        rf_w1     = cpu_waddr;
        rf_wdata  = cpu_wdata;
        cpu_stall = 1'b0;
`ifdef REGFILE_INIT_SWEEP_EN
        if (r_state == S_INIT) begin
            rf_we     = 1'b1;
            rf_w1     = r_idx;
            rf_wdata  = (r_idx == AW'(SP_IDX)) ? SP_INIT : '0;
            cpu_stall = 1'b1;
        end else
`endif
        if (w_grant && dbg_we) begin
            rf_we     = (dbg_addr != '0);
            rf_w1     = dbg_addr;
            rf_wdata  = dbg_wdata;
            cpu_stall = cpu_we;
        end else if (w_grant) begin
            rf_r1     = dbg_addr;
            rf_we     = 1'b0;
            cpu_stall = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= RST_STATE;
            r_wait_cnt  <= '0;
            r_gnt       <= 1'b0;
            r_rvalid    <= 1'b0;
            r_rdata     <= '0;
            r_init_done <= RST_DONE;
`ifdef REGFILE_INIT_SWEEP_EN
            r_idx       <= '0;
`endif
        end else begin
            r_gnt    <= w_grant;
            r_rvalid <= 1'b0;
            case (r_state)
`ifdef REGFILE_INIT_SWEEP_EN
                S_INIT: begin
                    r_idx <= r_idx + AW'(1);
                    if (r_idx == AW'(NREG - 1)) begin
                        r_state     <= S_RUN;
                        r_init_done <= 1'b1;
                    end
                end
`endif
                S_RUN: begin
                    if (w_grant) begin
                        r_wait_cnt <= '0;
                        if (!dbg_we) r_state <= S_DBG_RD;
                    end else if (w_dbg_elig) begin
                        if (r_wait_cnt != WCW'(MAX_WAIT)) r_wait_cnt <= r_wait_cnt + WCW'(1);
                    end else begin
                        r_wait_cnt <= '0;
                    end
                end
                S_DBG_RD: begin
                    r_rvalid   <= 1'b1;
                    r_rdata    <= rf_rdata1;
                    r_wait_cnt <= '0;
                    r_state    <= S_RUN;
                end
                default: r_state <= S_RUN;
            endcase
        end
    end

    assign dbg_gnt    = r_gnt;
    assign dbg_rvalid = r_rvalid;
    assign dbg_rdata  = r_rdata;
    assign init_done  = r_init_done;

endmodule
